btpipe_multichan_source: RTL and testbench
==========================================

Name: btpipe_multichan_source

Overview:
- Multi-channel data source that sits in front of the okBTPipeOut endpoint.
- Collects 16-bit words from up to CHANNELS producers, or from internal test-pattern generators.
- Arbitrates them round-robin into one shared FIFO.
- Drives the block-throttled pipe handshake so the host reads only when a full block of BLOCK_WORDS is buffered.
- Mode, enable and flag-clear come from okWireIn bits; status goes back via okWireOut.

Parameters:
- DATA_W, 16, word width; equals the pipe width.
- CHANNELS, 4, number of producer channels (1..8).
- DEPTH_LOG2, 10, FIFO depth is 2**DEPTH_LOG2 words.
- BLOCK_WORDS, 256, host block length in words; must be ≤ 2**DEPTH_LOG2.

Ports:
- ti_clk, input, 1, host-interface clock; all logic in this domain.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, capture/generation enable (wire-in bit).
- mode, input, 2, 0 = raw capture, 1 = counter pattern, 2 = tagged capture, 3 = reserved (acts as 0).
- clear_flags, input, 1, single-cycle clear of sticky flags.
- ch_valid, input, CHANNELS, per-channel sample strobe.
- ch_data, input, CHANNELS*DATA_W, per-channel samples; channel i at [i*DATA_W +: DATA_W].
- ep_read, input, 1, pipe read strobe from okBTPipeOut.
- ep_blockstrobe, input, 1, start-of-block strobe from okBTPipeOut.
- ep_datain, output, DATA_W, word to the pipe.
- ep_ready, output, 1, a full block is available.
- fill_count, output, DEPTH_LOG2+1, FIFO occupancy.
- overflow, output, 1, sticky: a sample was dropped.
- underflow, output, 1, sticky: read on empty FIFO, or more than BLOCK_WORDS reads in one block.

Behaviour:
- Reset values: all outputs 0. FIFO empty, holding registers empty, round-robin pointer 0, pattern counter 0.
- Holding stage:
  - Each channel has a 1-deep holding register.
  - ch_valid[i] with an empty holder: capture the sample.
  - ch_valid[i] with a full holder, not released this cycle: drop the new sample and set overflow.
  - Holder released and new valid in the same cycle: accept the new sample, no drop.
- Arbiter:
  - At most one FIFO write per cycle.
  - Grant goes to the first full holder at or after the rr pointer (wraps CHANNELS-1 → 0).
  - On a grant the pointer moves to grant+1 mod CHANNELS.
  - No grant while the FIFO is full or enable=0. Holders keep their data; they are not flushed.
- Mode 2: the top TAG_W = clog2(CHANNELS) bits of the written word are replaced with the channel index; lower bits pass through unchanged. With CHANNELS=1, TAG_W=0 and mode 2 behaves as mode 0.
- Mode 1:
  - Channels are ignored and holders are not loaded.
  - One word per cycle while enable=1 and the FIFO is not full.
  - Value = 16-bit counter, incremented only on a write; wraps 0xFFFF → 0x0000.
  - Switching into mode 1 does not reset the counter.
- FIFO read side (first-word-fall-through):
  - ep_datain always shows the head word.
  - ep_read pops at the clock edge; the next word appears the following cycle.
  - ep_read on empty: no pop, ep_datain holds its last value, underflow set.
- Simultaneous write and read when full: legal, count unchanged. Same on empty: the written word is not bypassed; it is visible the next cycle.
- ep_ready:
  - Registered: 1 in the cycle after fill_count ≥ BLOCK_WORDS.
  - Cleared the cycle after ep_blockstrobe; re-evaluated once BLOCK_WORDS reads of that block have completed.
- Block read counter:
  - Cleared on ep_blockstrobe and counts ep_reads.
  - A read beyond BLOCK_WORDS sets underflow and still pops if data is present.
- fill_count: registered, exact, range 0..2**DEPTH_LOG2.
- clear_flags clears overflow and underflow. An error event in the same cycle wins, so the flag stays 1.
- enable=0 stops writes only; reads and handshake continue.
- Reset mid-block takes effect in one cycle: FIFO discarded, ep_ready=0, counters and flags zeroed.

Decomposition:
- Package btpipe_pkg:
  - mode encodings MODE_RAW=0, MODE_CNT=1, MODE_TAG=2;
  - clog2 function;
  - TAG_W derivation.
- Sub-module sync_fifo_fwft:
  - parameters DATA_W and DEPTH_LOG2;
  - ports wr_en/wr_data/full, rd_en/rd_data/empty, count;
  - uses ti_clk and reset.
- Holding registers, arbiter, pattern generator and handshake logic stay in the top block.

Test Plan:
- Mode 1, enable=1, BLOCK_WORDS=256: ep_ready rises the cycle after fill_count=256. Strobe, then 256 reads return 0x0000..0x00FF in order. ep_ready drops after the strobe. underflow=0.
- Mode 2, CHANNELS=4, all ch_valid pulsed once with data 0x0ABC: FIFO holds 0x0ABC, 0x4ABC, 0x8ABC, 0xCABC in channel order 0→3. rr pointer ends at 0.
- Channel 1 valid on two consecutive cycles while the FIFO is full: the first sample is held, the second is dropped. overflow=1. clear_flags then gives overflow=0. Draining one word lets the held sample be written.
- Read on empty FIFO: ep_datain unchanged, underflow=1. A 257th read in a block also sets underflow.
- FIFO at full (1024) with a simultaneous channel grant and ep_read: fill_count stays 1024 and no overflow is flagged.
- reset asserted mid-block after 100 reads: next cycle fill_count=0, ep_ready=0, ep_datain=0, flags=0. Mode-1 counter restarts at 0x0000.

Source files
------------

// File: rtl/btpipe_pkg.sv
// btpipe_pkg: shared mode encodings and width helpers for the block-throttled pipe source
package btpipe_pkg;
  localparam logic [1:0] MODE_RAW = 2'd0;
  localparam logic [1:0] MODE_CNT = 2'd1;
  localparam logic [1:0] MODE_TAG = 2'd2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int tag_w(input int channels);
    return clog2(channels);
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO whose output holds the last popped word while empty
module sync_fifo_fwft #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  ti_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic wr_ok, rd_ok;
  assign full    = cnt_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign rd_data = empty ? last_q : mem_q[rp_q];
  assign count   = cnt_q;
  // pointer/count bookkeeping; a write while full is allowed only alongside a real pop
  always_comb begin
    rd_ok  = rd_en & !empty;
    wr_ok  = wr_en & (!full | rd_ok);
    wp_d   = wp_q + DEPTH_LOG2'(wr_ok);
    rp_d   = rp_q + DEPTH_LOG2'(rd_ok);
    cnt_d  = cnt_q + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
    last_d = rd_ok ? mem_q[rp_q] : last_q;
  end
  // control state
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  // storage array, contents are don't-care until written
  always_ff @(posedge ti_clk) begin
    if (wr_ok) mem_q[wp_q] <= wr_data;
  end
endmodule

// File: rtl/btpipe_multichan_source.sv
// btpipe_multichan_source: round-robin multi-channel capture into a FIFO behind a block-throttled pipe
module btpipe_multichan_source
  import btpipe_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CHANNELS    = 4,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                         ti_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic                         clear_flags,
  input  logic [CHANNELS-1:0]          ch_valid,
  input  logic [CHANNELS*DATA_W-1:0]   ch_data,
  input  logic                         ep_read,
  input  logic                         ep_blockstrobe,
  output logic [DATA_W-1:0]            ep_datain,
  output logic                         ep_ready,
  output logic [DEPTH_LOG2:0]          fill_count,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int TAG_W = tag_w(CHANNELS);
  localparam int IDX_W = TAG_W > 0 ? TAG_W : 1;
  localparam int BC_W  = clog2(BLOCK_WORDS + 2);
  logic [CHANNELS-1:0] hv_q, hv_d, rel;
  logic [DATA_W-1:0] hd_q [CHANNELS];
  logic [DATA_W-1:0] hd_d [CHANNELS];
  logic [IDX_W-1:0] rr_q, rr_d, gnt, idx;
  logic [DATA_W-1:0] cnt_q, cnt_d, wr_data, raw, tag_mask;
  logic [BC_W-1:0] bc_q, bc_d;
  logic gnt_v, can_wr, cnt_mode, tag_mode, wr_en, full, empty, drop;
  logic in_blk_q, in_blk_d, ready_q, ready_d, ovf_q, ovf_d, udf_q, udf_d;
  assign cnt_mode  = mode == MODE_CNT;
  assign tag_mode  = mode == MODE_TAG;
  assign can_wr    = enable & (!full | ep_read);
  assign ep_ready  = ready_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  // first full holder at or after the rr pointer; descending scan lets the nearest one win
  always_comb begin
    gnt   = rr_q;
    gnt_v = 1'b0;
    idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_q) + k) % CHANNELS);
      if (hv_q[idx]) begin
        gnt   = idx;
        gnt_v = 1'b1;
      end
    end
  end
  // write word selection, channel tagging, pattern counter and pointer advance
  always_comb begin
    raw      = hd_q[gnt];
    tag_mask = ~({DATA_W{1'b1}} >> TAG_W);
    wr_en    = can_wr & (cnt_mode | gnt_v);
    wr_data  = cnt_mode ? cnt_q :
               tag_mode ? ((raw & ~tag_mask) | ((DATA_W'(gnt) << (DATA_W - TAG_W)) & tag_mask)) : raw;
    rel      = (wr_en & !cnt_mode) ? (CHANNELS'(1) << gnt) : '0;
    cnt_d    = cnt_q + DATA_W'(wr_en & cnt_mode);
    rr_d     = (wr_en & !cnt_mode) ? ((int'(gnt) == CHANNELS - 1) ? '0 : gnt + 1'b1) : rr_q;
  end
  // holders: a release frees the slot for a same-cycle sample; otherwise a busy slot drops it
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      hv_d[i] = hv_q[i] & !rel[i];
      hd_d[i] = hd_q[i];
      if (ch_valid[i] & !cnt_mode) begin
        if (hv_d[i]) drop = 1'b1;
        else begin
          hv_d[i] = 1'b1;
          hd_d[i] = ch_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end
  // block handshake: ready withheld from the strobe until the block's reads are done
  always_comb begin
    bc_d     = ep_blockstrobe ? '0 : (ep_read && bc_q <= BC_W'(BLOCK_WORDS)) ? bc_q + 1'b1 : bc_q;
    in_blk_d = ep_blockstrobe | (in_blk_q & (bc_d < BC_W'(BLOCK_WORDS)));
    ready_d  = !ep_blockstrobe & !in_blk_q & (fill_count >= (DEPTH_LOG2+1)'(BLOCK_WORDS));
    udf_d    = (ep_read & (empty | (bc_q >= BC_W'(BLOCK_WORDS)))) | (udf_q & !clear_flags);
    ovf_d    = drop | (ovf_q & !clear_flags);
  end
  // state registers
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      hv_q     <= '0;
      hd_q     <= '{default: '0};
      rr_q     <= '0;
      cnt_q    <= '0;
      bc_q     <= '0;
      in_blk_q <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      hv_q     <= hv_d;
      hd_q     <= hd_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      bc_q     <= bc_d;
      in_blk_q <= in_blk_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .ti_clk  (ti_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (ep_read),
    .rd_data (ep_datain),
    .empty   (empty),
    .count   (fill_count)
  );
endmodule

// File: tb/tb_btpipe_multichan_source.sv
// tb_btpipe_multichan_source: scoreboard-driven scenarios for the multi-channel pipe source
module tb_btpipe_multichan_source;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int DL = 10;
  localparam int BW = 256;
  logic ti_clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic clear_flags = 1'b0;
  logic [CH-1:0] ch_valid = '0;
  logic [CH*DW-1:0] ch_data = '0;
  logic ep_read = 1'b0;
  logic ep_blockstrobe = 1'b0;
  logic [DW-1:0] ep_datain;
  logic ep_ready;
  logic [DL:0] fill_count;
  logic overflow, underflow;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  logic to;

  btpipe_multichan_source #(.DATA_W(DW), .CHANNELS(CH), .DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
    .ti_clk(ti_clk), .reset(reset), .enable(enable), .mode(mode), .clear_flags(clear_flags),
    .ch_valid(ch_valid), .ch_data(ch_data), .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
    .ep_datain(ep_datain), .ep_ready(ep_ready), .fill_count(fill_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic tick;
    @(posedge ti_clk);
    @(negedge ti_clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; clear_flags = 1'b0;
    ch_valid = '0; ch_data = '0; ep_read = 1'b0; ep_blockstrobe = 1'b0;
    tick; tick;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_fill(input int n, output logic timed_out);
    int t = 0;
    while (int'(fill_count) < n && t < 5000) begin tick; t++; end
    timed_out = int'(fill_count) < n;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (ep_datain !== 16'h0) begin failures++; $display("FAIL reset_datain got=%h exp=0000", ep_datain); end
    checks++; if (ep_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ep_ready); end
    checks++; if (fill_count !== 11'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_counter_block;
    do_reset;
    for (int i = 0; i < BW; i++) exp_q.push_back(DW'(i));
    mode = 2'd1; enable = 1'b1;
    wait_fill(BW, to);
    checks++; if (to || fill_count !== 11'd256) begin failures++; $display("FAIL cnt_fill got=%0d exp=256", fill_count); end
    checks++; if (ep_ready !== 1'b0) begin failures++; $display("FAIL cnt_ready_early got=%b exp=0", ep_ready); end
    tick;
    checks++; if (ep_ready !== 1'b1) begin failures++; $display("FAIL cnt_ready_rise got=%b exp=1", ep_ready); end
    enable = 1'b0;
    ep_blockstrobe = 1'b1; tick; ep_blockstrobe = 1'b0;
    checks++; if (ep_ready !== 1'b0) begin failures++; $display("FAIL cnt_ready_drop got=%b exp=0", ep_ready); end
    ep_read = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (ep_datain !== e) begin failures++; $display("FAIL cnt_word got=%h exp=%h", ep_datain, e); end
      tick;
    end
    ep_read = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL cnt_no_udf got=%b exp=0", underflow); end
    ep_read = 1'b1; tick; ep_read = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL cnt_extra_read_udf got=%b exp=1", underflow); end
    checks++; if (ep_datain !== 16'h0100) begin failures++; $display("FAIL cnt_extra_read_word got=%h exp=0100", ep_datain); end
    clear_flags = 1'b1; tick; clear_flags = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL cnt_clear_udf got=%b exp=0", underflow); end
  endtask

  task automatic test_tag_rr;
    do_reset;
    mode = 2'd2; enable = 1'b1;
    ch_data = {4{16'h0ABC}}; ch_valid = 4'hF;
    exp_q.push_back(16'h0ABC); exp_q.push_back(16'h4ABC); exp_q.push_back(16'h8ABC); exp_q.push_back(16'hCABC);
    tick; ch_valid = '0;
    repeat (4) tick;
    checks++; if (fill_count !== 11'd4) begin failures++; $display("FAIL tag_fill got=%0d exp=4", fill_count); end
    ch_data = '0; ch_data[0 +: DW] = 16'h0111; ch_data[3*DW +: DW] = 16'h0333; ch_valid = 4'b1001;
    exp_q.push_back(16'h0111); exp_q.push_back(16'hC333);
    tick; ch_valid = '0;
    tick; tick;
    checks++; if (fill_count !== 11'd6) begin failures++; $display("FAIL tag_fill2 got=%0d exp=6", fill_count); end
    ep_read = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (ep_datain !== e) begin failures++; $display("FAIL tag_word got=%h exp=%h", ep_datain, e); end
      tick;
    end
    ep_read = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL tag_no_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow_full;
    do_reset;
    for (int i = 0; i < 1024; i++) exp_q.push_back(DW'(i));
    mode = 2'd1; enable = 1'b1;
    wait_fill(1024, to);
    checks++; if (to || fill_count !== 11'd1024) begin failures++; $display("FAIL full_fill got=%0d exp=1024", fill_count); end
    mode = 2'd0;
    ch_data[DW +: DW] = 16'h1111; ch_valid = 4'b0010; tick;
    ch_data[DW +: DW] = 16'h2222; tick;
    ch_valid = '0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    clear_flags = 1'b1; tick; clear_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    exp_q.push_back(16'h1111);
    e = exp_q.pop_front();
    checks++; if (ep_datain !== e) begin failures++; $display("FAIL full_head got=%h exp=%h", ep_datain, e); end
    ep_read = 1'b1; tick; ep_read = 1'b0;
    checks++; if (fill_count !== 11'd1024) begin failures++; $display("FAIL full_rw_fill got=%0d exp=1024", fill_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_rw_ovf got=%b exp=0", overflow); end
    ep_read = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (ep_datain !== e) begin failures++; $display("FAIL drain_word got=%h exp=%h", ep_datain, e); end
      tick;
    end
    ep_read = 1'b0;
    checks++; if (fill_count !== 11'd0) begin failures++; $display("FAIL drain_fill got=%0d exp=0", fill_count); end
  endtask

  task automatic test_underflow_empty;
    do_reset;
    mode = 2'd2; enable = 1'b1;
    ch_data[2*DW +: DW] = 16'h0055; ch_valid = 4'b0100; tick; ch_valid = '0;
    tick; enable = 1'b0;
    ep_blockstrobe = 1'b1; tick; ep_blockstrobe = 1'b0;
    checks++; if (ep_datain !== 16'h8055 || fill_count !== 11'd1) begin failures++; $display("FAIL udf_setup got=%h/%0d exp=8055/1", ep_datain, fill_count); end
    ep_read = 1'b1; tick; ep_read = 1'b0;
    checks++; if (underflow !== 1'b0 || fill_count !== 11'd0) begin failures++; $display("FAIL udf_last_pop got=%b/%0d exp=0/0", underflow, fill_count); end
    ep_read = 1'b1; tick; ep_read = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_empty_read got=%b exp=1", underflow); end
    checks++; if (ep_datain !== 16'h8055) begin failures++; $display("FAIL udf_hold_word got=%h exp=8055", ep_datain); end
    clear_flags = 1'b1; ep_read = 1'b1; tick; clear_flags = 1'b0; ep_read = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_event_beats_clear got=%b exp=1", underflow); end
  endtask

  task automatic test_reset_mid_block;
    do_reset;
    mode = 2'd1; enable = 1'b1;
    wait_fill(BW, to);
    checks++; if (to) begin failures++; $display("FAIL mid_fill got=%0d exp>=256", fill_count); end
    enable = 1'b0;
    ep_blockstrobe = 1'b1; tick; ep_blockstrobe = 1'b0;
    ep_read = 1'b1; repeat (100) tick; ep_read = 1'b0;
    checks++; if (ep_datain !== 16'd100) begin failures++; $display("FAIL mid_head got=%h exp=0064", ep_datain); end
    reset = 1'b1; tick;
    checks++; if (fill_count !== 11'd0 || ep_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_fill_ready got=%0d/%b exp=0/0", fill_count, ep_ready); end
    checks++; if (ep_datain !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL mid_rst_data_flags got=%h/%b%b exp=0000/00", ep_datain, overflow, underflow); end
    reset = 1'b0; enable = 1'b1; tick;
    checks++; if (ep_datain !== 16'h0000 || fill_count !== 11'd1) begin failures++; $display("FAIL mid_restart_first got=%h/%0d exp=0000/1", ep_datain, fill_count); end
    ep_read = 1'b1; tick; ep_read = 1'b0; enable = 1'b0;
    checks++; if (ep_datain !== 16'h0001) begin failures++; $display("FAIL mid_restart_second got=%h exp=0001", ep_datain); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge ti_clk);
    test_reset;
    test_counter_block;
    test_tag_rr;
    test_overflow_full;
    test_underflow_empty;
    test_reset_mid_block;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
